// File: rtl/maq_est_pkg.sv
// rtl/maq_est_pkg.sv - shared state encoding and width helper for the multi-channel danger FSM
package maq_est_pkg;

  // Per-channel state encoding.
  typedef enum logic [2:0] {
    INACTIVO = 3'd0,
    REPOSO   = 3'd1,
    SOSPECHA = 3'd2,
    ALARMA   = 3'd3,
    RETENIDA = 3'd4
  } est_t;

  // Persistence counter width: wide enough to hold DEB_CYC.
  function automatic int cnt_w(input int deb_cyc);
    return (deb_cyc < 1) ? 1 : $clog2(deb_cyc + 1);
  endfunction

endpackage

// File: rtl/maq_est_canal.sv
// rtl/maq_est_canal.sv - one alarm channel: persistence filter, latched alarm, ack release
module maq_est_canal
  import maq_est_pkg::*;
#(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic EN,
  input  logic cond,
  input  logic ack,
  input  logic blink,
  output logic led,
  output logic activo
);

  localparam int CW = cnt_w(DEB_CYC);

  est_t          st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state and persistence counter; EN low dominates everything.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (!EN) begin
      st_d  = INACTIVO;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        INACTIVO: begin
          // Enabling only arms the channel; cond is looked at from the next edge.
          st_d  = REPOSO;
          cnt_d = '0;
        end
        REPOSO: begin
          cnt_d = '0;
          if (cond) begin
            if (DEB_CYC == 1) begin
              st_d = ALARMA;
            end else begin
              st_d  = SOSPECHA;
              cnt_d = CW'(1);
            end
          end
        end
        SOSPECHA: begin
          if (!cond) begin
            st_d  = REPOSO;
            cnt_d = '0;
          end else if (cnt_q == CW'(DEB_CYC - 1)) begin
            st_d  = ALARMA;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ALARMA: begin
          // ack has no effect while the condition may still be present.
          if (!cond) st_d = RETENIDA;
        end
        RETENIDA: begin
          // A returning condition beats a simultaneous ack.
          if (cond) begin
            st_d = ALARMA;
          end else if (ack) begin
            st_d  = REPOSO;
            cnt_d = '0;
          end
        end
        default: begin
          st_d  = REPOSO;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= INACTIVO;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Moore outputs decoded from the state register only.
  assign activo = (st_q == ALARMA) || (st_q == RETENIDA);
  assign led    = (st_q == ALARMA) || ((st_q == RETENIDA) && blink);

endmodule

// File: rtl/maq_est_multi.sv
// rtl/maq_est_multi.sv - N-channel danger monitor with alarm summary; blinking held alarms under MAQ_EST_PARPADEO_EN
module maq_est_multi
  import maq_est_pkg::*;
#(
  parameter int N_CANALES = 4,
  parameter int DEB_CYC   = 16,
  parameter int BLINK_DIV = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           EN,
  input  logic [N_CANALES-1:0]           temp_alta,
  input  logic [N_CANALES-1:0]           hn,
  input  logic [N_CANALES-1:0]           ack,
  output logic [N_CANALES-1:0]           led_pelig,
  output logic                           alarma_any,
  output logic [$clog2(N_CANALES+1)-1:0] alarma_cnt
);

  localparam int NW = $clog2(N_CANALES + 1);

  logic                 blink;
  logic [N_CANALES-1:0] activo;
  logic [NW-1:0]        cnt_sum;

`ifdef MAQ_EST_PARPADEO_EN
  logic [BLINK_DIV:0] blk_div_q, blk_div_d;

  // Free-running divider; its top bit paces the held-alarm blink.
  always_comb begin
    blk_div_d = blk_div_q + (BLINK_DIV + 1)'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_div_q <= '0;
    else        blk_div_q <= blk_div_d;
  end

  assign blink = blk_div_q[BLINK_DIV];
`else
  assign blink = 1'b1;
`endif

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    maq_est_canal #(
      .DEB_CYC(DEB_CYC)
    ) u_canal (
      .clk    (clk),
      .rst_n  (rst_n),
      .EN     (EN),
      .cond   (hn[i] & temp_alta[i]),
      .ack    (ack[i]),
      .blink  (blink),
      .led    (led_pelig[i]),
      .activo (activo[i])
    );
  end

  // Count channels holding an alarm (solid state, never blinking).
  always_comb begin
    cnt_sum = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      cnt_sum = cnt_sum + NW'(activo[i]);
    end
  end

  assign alarma_cnt = cnt_sum;
  assign alarma_any = |activo;

endmodule
